// File: rtl/dsp_result_accum_if.sv
// Product-in / frame-total-out handshake bundle for dsp_result_accum.
// master drives products and out_ready; slave is the accumulator.
interface dsp_result_accum_if #(
   parameter int DATA_W = 48,
   parameter int ACC_W  = 56,
   parameter int LEN_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [LEN_W-1:0]  frame_len;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_sat;

   modport master (
      output in_valid, in_data, frame_len, out_ready,
      input  in_ready, out_valid, out_sum, out_sat
   );

   modport slave (
      input  in_valid, in_data, frame_len, out_ready,
      output in_ready, out_valid, out_sum, out_sat
   );
endinterface

// File: rtl/dsp_result_accum.sv
// Sums frames of signed DSP products into a wide total with one output holding register.
// Optional ACCUM_SAT_EN: clamp each partial sum to the signed ACC_W range and flag it.
module dsp_result_accum #(
   parameter int DATA_W = 48,
   parameter int ACC_W  = 56,
   parameter int LEN_W  = 8
) (
   input logic               clk,
   input logic               rst,
   dsp_result_accum_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]              state;
   logic signed [ACC_W-1:0] acc, ext, base, sum_nxt, out_sum_q;
   logic [LEN_W:0]          len, cnt, len_new, len_cur, cnt_nxt;
   logic                    in_ready, accept, transfer, opening, last, out_valid_q;

   always_comb begin
      in_ready = !rst && ((state != S_HOLD) || bus.out_ready);
      accept   = bus.in_valid && in_ready;
      transfer = out_valid_q && bus.out_ready;
      // IDLE and HOLD both open a fresh frame on accept
      opening  = (state != S_ACCUM);
      len_new  = (bus.frame_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.frame_len};
      len_cur  = opening ? len_new : len;
      cnt_nxt  = opening ? (LEN_W+1)'(1) : cnt + (LEN_W+1)'(1);
      last     = (cnt_nxt == len_cur);
      ext      = ACC_W'($signed(bus.in_data));
      base     = opening ? '0 : acc;
   end

`ifdef ACCUM_SAT_EN
   logic signed [ACC_W:0] wide;
   logic                  ovf, sat_acc, sat_nxt, out_sat_q;

   always_comb begin
      wide = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
      ovf  = wide[ACC_W] ^ wide[ACC_W-1];
      if (!ovf)
         sum_nxt = wide[ACC_W-1:0];
      else if (wide[ACC_W])
         sum_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      else
         sum_nxt = {1'b0, {(ACC_W-1){1'b1}}};
      sat_nxt = ovf || (!opening && sat_acc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_acc   <= 1'b0;
         out_sat_q <= 1'b0;
      end else if (accept) begin
         sat_acc <= sat_nxt;
         if (last) out_sat_q <= sat_nxt;
      end
   end

   assign bus.out_sat = out_sat_q;
`else
   always_comb sum_nxt = base + ext;

   assign bus.out_sat = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         acc         <= '0;
         cnt         <= '0;
         len         <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            acc   <= sum_nxt;
            cnt   <= cnt_nxt;
            state <= last ? S_HOLD : S_ACCUM;
            if (opening) len <= len_new;
         end else if (transfer) begin
            state <= S_IDLE;
         end
         if (accept && last) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_nxt;
         end else if (transfer) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
endmodule
